// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: FSM state encoding and
// default widths that match the 16-bit processor's control logic.
package mul_seq_pkg;

    // Operand/result width of the processor datapath.
    localparam int MUL_WIDTH = 16;
    // Register-file address width.
    localparam int MUL_RD_W  = 3;
    // Iteration counter width; 2**MUL_CNT_W must exceed MUL_WIDTH.
    localparam int MUL_CNT_W = 5;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: holds the shifted multiplicand (a), the
// shifted multiplier (b) and the running low-half accumulator (acc).
// The controlling FSM asserts load once to capture operands and step once
// per iteration. acc_next is the accumulator value after the current step;
// the FSM captures it directly into the write-back register.
// Optional feature macro: MUL_EARLY_EXIT_EN adds the b_empty_next output,
// which reports that the multiplier will be zero after this step.
module mul_shift_add_dp import mul_seq_pkg::*; #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef MUL_EARLY_EXIT_EN
    output logic             b_empty_next,
`endif
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;

    // Add the multiplicand when the current multiplier LSB is set; the sum
    // wraps at WIDTH bits because only the low product half is kept.
    always_comb begin
        acc_next = acc;
        if (b[0]) begin
            acc_next = acc + a;
        end
    end

`ifdef MUL_EARLY_EXIT_EN
    // The multiplier after this step's right shift is zero exactly when
    // every bit above the LSB is already zero.
    assign b_empty_next = (b[WIDTH-1:1] == '0);
`endif

    // Operand capture on load, one shift-add iteration per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= '0;
            b   <= '0;
            acc <= '0;
        end else if (load) begin
            a   <= a_in;
            b   <= b_in;
            acc <= '0;
        end else if (step) begin
            a   <= a << 1;
            b   <= b >> 1;
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle multiply sequencer. On an accepted mul_start it freezes
// fetch, runs WIDTH shift-add iterations, then issues a single register
// file write of the low product half (wb_en/done pulse for one cycle).
// Optional feature macro: MUL_EARLY_EXIT_EN ends the RUN phase as soon as
// the remaining multiplier bits are all zero; the product is unchanged.
//
// Handshake: mul_start is a request sampled only in IDLE; there is no
// ready/ack. A request seen in IDLE is accepted on that edge, requests in
// RUN or WB are dropped. The current FSM state is kept in the named
// signal 'state' (type state_t) for observation.
module mul_seq_ctrl import mul_seq_pkg::*; #(
    parameter int WIDTH = MUL_WIDTH,
    parameter int RD_W  = MUL_RD_W,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [RD_W-1:0]  rd_in,
    output logic             stall,
    output logic             busy,
    output logic             wb_en,
    output logic [RD_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [RD_W-1:0]  rd_q;
    logic             load;
    logic             step;
    logic             last_iter;
    logic [WIDTH-1:0] acc_next;
`ifdef MUL_EARLY_EXIT_EN
    logic             b_empty_next;
`endif

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .a_in         (op_a),
        .b_in         (op_b),
`ifdef MUL_EARLY_EXIT_EN
        .b_empty_next (b_empty_next),
`endif
        .acc_next     (acc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath controls.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
                last_iter = (count == CNT_W'(WIDTH - 1)) || b_empty_next;
`else
                last_iter = (count == CNT_W'(WIDTH - 1));
`endif
                if (last_iter) begin
                    state_next = WB;
                end
            end
            WB: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Iteration counter: cleared on accept, advanced once per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    // Destination register captured with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (load) begin
            rd_q <= rd_in;
        end
    end

    // Registered write-back outputs: loaded on the final iteration so they
    // are valid for exactly the WB cycle, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            done    <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_en   <= last_iter;
            done    <= last_iter;
            wb_rd   <= last_iter ? rd_q : '0;
            wb_data <= last_iter ? acc_next : '0;
        end
    end

    // Busy covers RUN and WB; stall also covers the accepting IDLE cycle so
    // fetch freezes in the same cycle the request appears.
    assign busy  = (state != IDLE);
    assign stall = busy | mul_start;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl. Expected products and write
// timing come from a reference model using plain integer arithmetic.
module tb_mul_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int RD_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             mul_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [RD_W-1:0]  rd_in;
    logic             stall;
    logic             busy;
    logic             wb_en;
    logic [RD_W-1:0]  wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             done;

    int cyc    = 0;
    int n_pass = 0;
    int n_chk  = 0;

    mul_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mul_start (mul_start),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .stall     (stall),
        .busy      (busy),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .done      (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return p[WIDTH-1:0];
    endfunction

    // Cycles from the accepting cycle T to the write-back cycle.
    function automatic int ref_latency(input logic [WIDTH-1:0] b);
        int sig_bits;
        int runs;
        sig_bits = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) sig_bits = i + 1;
        end
`ifdef MUL_EARLY_EXIT_EN
        runs = (sig_bits < 1) ? 1 : sig_bits;
`else
        runs = (sig_bits > WIDTH) ? sig_bits : WIDTH;
`endif
        return runs + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mul_start = 1'b0;
        op_a      = WIDTH'($urandom);
        op_b      = WIDTH'($urandom);
        rd_in     = RD_W'($urandom);
    endtask

    task automatic wait_wb(input int bound, output bit seen, output int at);
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (wb_en === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (wb_en !== 1'b0) $display("FAIL reset_wb_en: got %b want 0", wb_en); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (wb_rd !== '0) $display("FAIL reset_wb_rd: got %0h want 0", wb_rd); else n_pass++;
        n_chk++; if (wb_data !== '0) $display("FAIL reset_wb_data: got %0h want 0", wb_data); else n_pass++;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        int t;
        int at;
        bit seen;
        next_cycle();
        mul_start = 1'b1; op_a = 16'd3; op_b = 16'd5; rd_in = 3'd2;
        t = cyc;
        @(negedge clk);
        n_chk++; if (stall !== 1'b1) $display("FAIL basic_stall_at_T: got %b want 1", stall); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL basic_busy_at_T: got %b want 0", busy); else n_pass++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy_run: got %b want 1", busy); else n_pass++;
        wait_wb(40, seen, at);
        n_chk++; if (seen !== 1'b1) $display("FAIL basic_wb_seen: got %b want 1", seen); else n_pass++;
        n_chk++; if (at !== t + ref_latency(16'd5)) $display("FAIL basic_wb_cycle: got %0d want %0d", at - t, ref_latency(16'd5)); else n_pass++;
        n_chk++; if (wb_rd !== 3'd2) $display("FAIL basic_wb_rd: got %0d want 2", wb_rd); else n_pass++;
        n_chk++; if (wb_data !== 16'd15) $display("FAIL basic_wb_data: got %0d want 15", wb_data); else n_pass++;
        n_chk++; if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else n_pass++;
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL basic_stall_after: got %b want 0", stall); else n_pass++;
        n_chk++; if (wb_en !== 1'b0) $display("FAIL basic_wb_en_pulse: got %b want 0", wb_en); else n_pass++;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] a_tab [5] = '{16'hFFFF, 16'h0100, 16'h0000, 16'h1234, 16'h8000};
        logic [WIDTH-1:0] b_tab [5] = '{16'hFFFF, 16'h0100, 16'h1234, 16'h0000, 16'h0002};
        logic [WIDTH-1:0] e_tab [5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        int t;
        int at;
        bit seen;
        logic [RD_W-1:0] rd;
        for (int n = 0; n < 5; n++) begin
            next_cycle();
            rd = RD_W'($urandom);
            mul_start = 1'b1; op_a = a_tab[n]; op_b = b_tab[n]; rd_in = rd;
            t = cyc;
            next_cycle();
            idle_inputs();
            wait_wb(40, seen, at);
            n_chk++; if (seen !== 1'b1) $display("FAIL dir%0d_wb_seen: got %b want 1", n, seen); else n_pass++;
            n_chk++; if (at !== t + ref_latency(b_tab[n])) $display("FAIL dir%0d_wb_cycle: got %0d want %0d", n, at - t, ref_latency(b_tab[n])); else n_pass++;
            n_chk++; if (wb_data !== e_tab[n]) $display("FAIL dir%0d_wb_data: got %0h want %0h", n, wb_data, e_tab[n]); else n_pass++;
            n_chk++; if (wb_rd !== rd) $display("FAIL dir%0d_wb_rd: got %0d want %0d", n, wb_rd, rd); else n_pass++;
        end
    endtask

    task automatic test_busy_start();
        int t;
        int at;
        int writes;
        int pulse_off;
        logic [RD_W-1:0]  got_rd;
        logic [WIDTH-1:0] got_d;
`ifdef MUL_EARLY_EXIT_EN
        pulse_off = 2;
`else
        pulse_off = 5;
`endif
        next_cycle();
        mul_start = 1'b1; op_a = 16'd7; op_b = 16'd6; rd_in = 3'd1;
        t = cyc;
        next_cycle();
        idle_inputs();
        writes = 0; at = -1; got_rd = '0; got_d = '0;
        while (cyc < t + 25) begin
            @(negedge clk);
            if (wb_en === 1'b1) begin
                writes++;
                if (writes == 1) begin
                    at = cyc; got_rd = wb_rd; got_d = wb_data;
                end
            end
            next_cycle();
            if (cyc == t + pulse_off) begin
                mul_start = 1'b1; op_a = 16'd9; op_b = 16'd9; rd_in = 3'd4;
            end else begin
                mul_start = 1'b0;
            end
        end
        n_chk++; if (writes !== 1) $display("FAIL busy_write_count: got %0d want 1", writes); else n_pass++;
        n_chk++; if (at !== t + ref_latency(16'd6)) $display("FAIL busy_wb_cycle: got %0d want %0d", at - t, ref_latency(16'd6)); else n_pass++;
        n_chk++; if (got_rd !== 3'd1) $display("FAIL busy_wb_rd: got %0d want 1", got_rd); else n_pass++;
        n_chk++; if (got_d !== ref_prod(16'd7, 16'd6)) $display("FAIL busy_wb_data: got %0d want %0d", got_d, ref_prod(16'd7, 16'd6)); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int t;
        int at;
        int writes;
        bit seen;
        next_cycle();
        mul_start = 1'b1; op_a = WIDTH'($urandom); op_b = 16'h8000 | WIDTH'($urandom); rd_in = 3'd6;
        t = cyc;
        next_cycle();
        idle_inputs();
        while (cyc < t + 8) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stall); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        writes = 0;
        while (cyc < t + 20) begin
            next_cycle();
            @(negedge clk);
            if (wb_en === 1'b1) writes++;
        end
        n_chk++; if (writes !== 0) $display("FAIL rstmid_no_write: got %0d want 0", writes); else n_pass++;
        next_cycle();
        mul_start = 1'b1; op_a = 16'd2; op_b = 16'd3; rd_in = 3'd7;
        t = cyc;
        next_cycle();
        idle_inputs();
        wait_wb(40, seen, at);
        n_chk++; if (at !== t + ref_latency(16'd3)) $display("FAIL rstmid_next_cycle: got %0d want %0d", at - t, ref_latency(16'd3)); else n_pass++;
        n_chk++; if (wb_data !== 16'd6) $display("FAIL rstmid_next_data: got %0d want 6", wb_data); else n_pass++;
        n_chk++; if (wb_rd !== 3'd7) $display("FAIL rstmid_next_rd: got %0d want 7", wb_rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t;
        int t2;
        int lat1;
        int lat2;
        int gaps;
        int nw;
        int w_at [2];
        logic [RD_W-1:0]  w_rd [2];
        logic [WIDTH-1:0] w_d  [2];
        lat1 = ref_latency(16'd4);
        lat2 = ref_latency(16'd5);
        next_cycle();
        mul_start = 1'b1; op_a = 16'd4; op_b = 16'd4; rd_in = 3'd3;
        t  = cyc;
        t2 = t + lat1 + 1;
        gaps = 0; nw = 0;
        w_at = '{-1, -1}; w_rd = '{'0, '0}; w_d = '{'0, '0};
        for (int k = 0; k <= lat1 + 1 + lat2; k++) begin
            @(negedge clk);
            if (stall !== 1'b1) gaps++;
            if (wb_en === 1'b1) begin
                if (nw < 2) begin
                    w_at[nw] = cyc; w_rd[nw] = wb_rd; w_d[nw] = wb_data;
                end
                nw++;
            end
            next_cycle();
            if (cyc == t2) begin
                mul_start = 1'b1; op_a = 16'd5; op_b = 16'd5; rd_in = 3'd5;
            end else begin
                mul_start = 1'b0;
            end
        end
        @(negedge clk);
        n_chk++; if (gaps !== 0) $display("FAIL b2b_stall_gaps: got %0d want 0", gaps); else n_pass++;
        n_chk++; if (nw !== 2) $display("FAIL b2b_write_count: got %0d want 2", nw); else n_pass++;
        n_chk++; if (w_at[0] !== t + lat1) $display("FAIL b2b_first_cycle: got %0d want %0d", w_at[0] - t, lat1); else n_pass++;
        n_chk++; if (w_d[0] !== 16'd16) $display("FAIL b2b_first_data: got %0d want 16", w_d[0]); else n_pass++;
        n_chk++; if (w_rd[0] !== 3'd3) $display("FAIL b2b_first_rd: got %0d want 3", w_rd[0]); else n_pass++;
        n_chk++; if (w_at[1] !== t2 + lat2) $display("FAIL b2b_second_cycle: got %0d want %0d", w_at[1] - t, t2 + lat2 - t); else n_pass++;
        n_chk++; if (w_d[1] !== 16'd25) $display("FAIL b2b_second_data: got %0d want 25", w_d[1]); else n_pass++;
        n_chk++; if (w_rd[1] !== 3'd5) $display("FAIL b2b_second_rd: got %0d want 5", w_rd[1]); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL b2b_stall_release: got %b want 0", stall); else n_pass++;
    endtask

    task automatic test_random();
        int t;
        int at;
        bit seen;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [RD_W-1:0]  rd;
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) next_cycle();
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1);
            rd = RD_W'($urandom);
            next_cycle();
            mul_start = 1'b1; op_a = a; op_b = b; rd_in = rd;
            t = cyc;
            next_cycle();
            idle_inputs();
            wait_wb(40, seen, at);
            n_chk++; if (seen !== 1'b1) $display("FAIL rand%0d_wb_seen: got %b want 1", n, seen); else n_pass++;
            n_chk++; if (at !== t + ref_latency(b)) $display("FAIL rand%0d_wb_cycle: got %0d want %0d", n, at - t, ref_latency(b)); else n_pass++;
            n_chk++; if (wb_data !== ref_prod(a, b)) $display("FAIL rand%0d_wb_data: a=%0h b=%0h got %0h want %0h", n, a, b, wb_data, ref_prod(a, b)); else n_pass++;
            n_chk++; if (wb_rd !== rd) $display("FAIL rand%0d_wb_rd: got %0d want %0d", n, wb_rd, rd); else n_pass++;
            n_chk++; if (done !== 1'b1) $display("FAIL rand%0d_done: got %b want 1", n, done); else n_pass++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        mul_start = 1'b0;
        op_a = '0;
        op_b = '0;
        rd_in = '0;
        test_reset();
        test_basic();
        test_directed();
        test_busy_start();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle multiply sequencer for the 16-bit custom processor.
- Decode raises the multiply flag. This block freezes fetch/PC, runs an iterative shift-add multiply over the shared operands, then issues one register-file write of the low product.
- Sits between the control logic (multiply flag, destination select) and the register-file write port / PC select.

Parameters:
- WIDTH, 16, operand and result width in bits.
- RD_W, 3, register-file address width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mul_start  in  1  decoded multiply request; sampled only in IDLE.
- op_a  in  WIDTH  multiplicand; latched on accepted start.
- op_b  in  WIDTH  multiplier; latched on accepted start.
- rd_in  in  RD_W  destination register; latched on accepted start.
- stall  out  1  holds PC and instruction fetch.
- busy  out  1  high in RUN and WB.
- wb_en  out  1  register-file write enable, one-cycle pulse.
- wb_rd  out  RD_W  write address, valid with wb_en.
- wb_data  out  WIDTH  low WIDTH bits of op_a*op_b, valid with wb_en.
- done  out  1  one-cycle pulse, coincident with wb_en.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; acc, shifted a/b, count, latched rd cleared. Outputs stall=0, busy=0, wb_en=0, done=0, wb_rd=0, wb_data=0.
- States: IDLE, RUN, WB. The encoding comes from the package.
- IDLE:
  - mul_start=1 at edge T: latch a=op_a, b=op_b, rd=rd_in; acc=0, count=0; next state RUN.
  - stall is combinational: stall = (state!=IDLE) | (state==IDLE & mul_start). Fetch therefore freezes in cycle T itself.
- RUN, one iteration per cycle:
  - if b[0], acc <= acc + a, truncated to WIDTH bits;
  - then a <= a<<1, b <= b>>1, count <= count+1.
  - After the iteration with count==WIDTH-1, next state is WB.
  - Baseline: RUN lasts exactly WIDTH cycles (T+1..T+WIDTH).
- WB, one cycle (T+WIDTH+1):
  - wb_en=1, done=1, wb_rd=latched rd, wb_data=acc. These are registered outputs.
  - stall stays 1. Next state is IDLE.
  - stall falls at T+WIDTH+2, unless mul_start is high again in that cycle.
- Total latency: start accepted at T, result written at T+WIDTH+1 (T+17 for WIDTH=16).
- mul_start while busy: ignored. No queuing, no effect on the in-flight operation.
- Back-to-back: mul_start sampled in the first IDLE cycle after WB is accepted normally. stall shows no gap cycle because of the combinational term.
- Signedness: unsigned operands. Low WIDTH bits are identical for two's-complement operands.
- Overflow: upper product bits are discarded. No flag.
- Reset mid-RUN or mid-WB: returns to IDLE next edge. No wb_en pulse, partial result discarded.
- Zero operand: completes with full baseline latency; wb_data=0.

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined: in RUN, if the post-shift b==0, the next state is WB regardless of count. Latency = max(1, index of highest set bit of op_b + 1) RUN cycles, then WB. op_b=0 gives one RUN cycle.
- Undefined: fixed WIDTH RUN cycles. The early-exit comparator logic is absent.
- wb_data is identical in both builds.

Decomposition:
- Shared package mul_seq_pkg holds:
  - the state enum/localparams (IDLE=2'd0, RUN=2'd1, WB=2'd2);
  - CNT_W default;
  - the WIDTH/RD_W defaults shared with the control logic.
- One sub-module, mul_shift_add_dp: registers a, b, acc and the adder, with load/step controls from the FSM. The FSM and counter stay in mul_seq_ctrl.

Test Plan:
- Basic multiply: op_a=3, op_b=5, rd_in=2, start at T -> stall high from T; wb_en=1, wb_rd=2, wb_data=15, done=1 at T+17; stall low at T+18.
- Truncation: 0xFFFF*0xFFFF -> wb_data=0x0001. Then 0x0100*0x0100 -> wb_data=0x0000.
- Start while busy: start (7,6,rd=1), then pulse mul_start with (9,9,rd=4) at T+5 -> only one write: rd=1, data=42 at T+17.
- Reset mid-op: start at T, rst=1 at T+8 -> next cycle stall=0, busy=0; no wb_en through T+20. A subsequent start (2,3) yields 6.
- Back-to-back: start (4,4,rd=3) at T, start (5,5,rd=5) held at T+18 -> writes 16 at T+17 and 25 at T+35; stall continuous T..T+35.
- MUL_EARLY_EXIT_EN defined: 3*5 at T -> wb_data=15 at T+4. op_b=0 at T -> wb_data=0 at T+2.
